// File: rtl/ramp_value_control_pkg.sv
// Shared definitions for the front-panel press-and-hold value controls:
// acceleration stage thresholds, stage decode and limit-mode encodings.
package ramp_value_control_pkg;

   localparam int STAGE_COUNT = 5;
   localparam int STAGE_W     = 3;
   localparam int SECS_W      = 4;
   localparam int SECS_MAX    = 15;

   // Hold time (whole seconds) that must be exceeded to enter stage 1..4.
   localparam int STAGE_THR [STAGE_COUNT-1] = '{1, 2, 4, 7};

   typedef enum int {
      COUPLE_NONE  = 0,
      COUPLE_FLOOR = 1,
      COUPLE_CEIL  = 2
   } couple_e;

   typedef enum int {
      WRAP_SAT = 0,
      WRAP_ON  = 1
   } wrap_e;

   function automatic logic [STAGE_W-1:0] stage_of(input logic [SECS_W-1:0] secs);
      logic [STAGE_W-1:0] s;
      s = '0;
      for (int i = 0; i < STAGE_COUNT - 1; i++) begin
         if (int'(secs) > STAGE_THR[i]) s = s + 1'b1;
      end
      return s;
   endfunction

endpackage

// File: rtl/ramp_value_control_if.sv
// Panel-side bundle of a value control: press/load requests in, value and status out.
interface ramp_value_control_if #(parameter int WIDTH = 12);

   logic             ENABLE;
   logic             UP;
   logic             DOWN;
   logic [WIDTH-1:0] BOUND;
   logic             LOAD;
   logic [WIDTH-1:0] LOAD_VAL;
   logic [WIDTH-1:0] VALUE;
   logic             AT_LIMIT;
   logic [2:0]       STAGE;

   modport master (
      output ENABLE, UP, DOWN, BOUND, LOAD, LOAD_VAL,
      input  VALUE, AT_LIMIT, STAGE
   );

   modport slave (
      input  ENABLE, UP, DOWN, BOUND, LOAD, LOAD_VAL,
      output VALUE, AT_LIMIT, STAGE
   );

endinterface

// File: rtl/ramp_value_control_hold_accel_timer.sv
// Hold timer: first step on the press, then steps at a period that shrinks by 4x
// per acceleration stage as whole seconds of hold accumulate.
module hold_accel_timer
   import ramp_value_control_pkg::*;
#(
   parameter int CLK_HZ  = 100000000,
   parameter int BASE_HZ = 2
) (
   input  logic               FF_CLOCK,
   input  logic               RESET,
   input  logic               enable,
   input  logic               held,
   output logic               step,
   output logic [STAGE_W-1:0] stage
);

   localparam int CW = $clog2(CLK_HZ);

   logic [CW-1:0]     period_m1 [STAGE_COUNT];
   logic [CW-1:0]     step_cnt_reg, step_cnt_next;
   logic [CW-1:0]     sub_cnt_reg, sub_cnt_next;
   logic [SECS_W-1:0] secs_reg, secs_next;
   logic              run_prev_reg;
   logic              blocked_reg, blocked_next;
   logic              run;

   for (genvar gi = 0; gi < STAGE_COUNT; gi++) begin : g_period
      assign period_m1[gi] = CW'(CLK_HZ / (BASE_HZ * (4 ** gi)) - 1);
   end

   // blocked_reg keeps a press that survived reset from stepping until it is released.
   always_comb begin
      run           = enable & held & ~blocked_reg;
      blocked_next  = blocked_reg & enable & held;
      stage         = stage_of(secs_reg);
      step          = run & (~run_prev_reg | (step_cnt_reg >= period_m1[stage]));
      step_cnt_next = '0;
      sub_cnt_next  = '0;
      secs_next     = '0;
      if (run) begin
         step_cnt_next = step ? '0 : step_cnt_reg + 1'b1;
         if (sub_cnt_reg == CW'(CLK_HZ - 1)) begin
            sub_cnt_next = '0;
            secs_next    = (secs_reg == SECS_W'(SECS_MAX)) ? secs_reg : secs_reg + 1'b1;
         end else begin
            sub_cnt_next = sub_cnt_reg + 1'b1;
            secs_next    = secs_reg;
         end
      end
   end

   always_ff @(posedge FF_CLOCK or posedge RESET) begin
      if (RESET) begin
         step_cnt_reg <= '0;
         sub_cnt_reg  <= '0;
         secs_reg     <= '0;
         run_prev_reg <= 1'b0;
         blocked_reg  <= 1'b1;
      end else begin
         step_cnt_reg <= step_cnt_next;
         sub_cnt_reg  <= sub_cnt_next;
         secs_reg     <= secs_next;
         run_prev_reg <= run;
         blocked_reg  <= blocked_next;
      end
   end

endmodule

// File: rtl/ramp_value_control.sv
// Press-and-hold value control: effective limit selection, step/load/wrap
// datapath and the registered at-limit flag, driven by hold_accel_timer.
module ramp_value_control
   import ramp_value_control_pkg::*;
#(
   parameter int WIDTH     = 12,
   parameter int RESET_VAL = 4095,
   parameter int LO_LIMIT  = 0,
   parameter int HI_LIMIT  = 4095,
   parameter int CLK_HZ    = 100000000,
   parameter int BASE_HZ   = 2,
   parameter int COUPLE    = 0,
   parameter int WRAP      = 0
) (
   input  logic FF_CLOCK,
   input  logic RESET,
   ramp_value_control_if.slave bus
);

   localparam int VW      = WIDTH + 1;
   localparam bit WRAP_EN = (WRAP == int'(WRAP_ON)) && (COUPLE == int'(COUPLE_NONE));

   logic [VW-1:0]      value_ext, bound_ext, load_ext, lo_eff, hi_eff;
   logic [WIDTH-1:0]   value_reg, value_next;
   logic               at_limit_reg, at_limit_next;
   logic               up_held, dn_held, step;
   logic [STAGE_W-1:0] stage;

   hold_accel_timer #(
      .CLK_HZ  (CLK_HZ),
      .BASE_HZ (BASE_HZ)
   ) u_timer (
      .FF_CLOCK (FF_CLOCK),
      .RESET    (RESET),
      .enable   (bus.ENABLE),
      .held     (bus.UP ^ bus.DOWN),
      .step     (step),
      .stage    (stage)
   );

   assign up_held   = bus.ENABLE & bus.UP & ~bus.DOWN;
   assign dn_held   = bus.ENABLE & bus.DOWN & ~bus.UP;
   assign value_ext = VW'(value_reg);
   assign bound_ext = VW'(bus.BOUND);
   assign load_ext  = VW'(bus.LOAD_VAL);

   always_comb begin
      lo_eff = VW'(LO_LIMIT);
      hi_eff = VW'(HI_LIMIT);
      if (COUPLE == int'(COUPLE_FLOOR) && bound_ext > lo_eff) lo_eff = bound_ext;
      if (COUPLE == int'(COUPLE_CEIL) && bound_ext < hi_eff) hi_eff = bound_ext;
   end

   // A value left outside the limits by a moving BOUND snaps to the violated limit.
   always_comb begin
      value_next = value_reg;
      if (bus.LOAD) begin
         if (load_ext < lo_eff)      value_next = WIDTH'(lo_eff);
         else if (load_ext > hi_eff) value_next = WIDTH'(hi_eff);
         else                        value_next = bus.LOAD_VAL;
      end else if (step) begin
         if (value_ext < lo_eff)      value_next = WIDTH'(lo_eff);
         else if (value_ext > hi_eff) value_next = WIDTH'(hi_eff);
         else if (up_held) begin
            if (value_ext < hi_eff) value_next = WIDTH'(value_ext + 1'b1);
            else if (WRAP_EN)       value_next = WIDTH'(lo_eff);
         end else if (dn_held) begin
            if (value_ext > lo_eff) value_next = WIDTH'(value_ext - 1'b1);
            else if (WRAP_EN)       value_next = WIDTH'(hi_eff);
         end
      end
      at_limit_next = ~WRAP_EN & ((up_held & (value_ext >= hi_eff)) |
                                  (dn_held & (value_ext <= lo_eff)));
   end

   always_ff @(posedge FF_CLOCK or posedge RESET) begin
      if (RESET) begin
         value_reg    <= WIDTH'(RESET_VAL);
         at_limit_reg <= 1'b0;
      end else begin
         value_reg    <= value_next;
         at_limit_reg <= at_limit_next;
      end
   end

   assign bus.VALUE    = value_reg;
   assign bus.AT_LIMIT = at_limit_reg;
   assign bus.STAGE    = stage;

endmodule

// File: tb/tb_ramp_value_control.sv
// Scoreboard bench for ramp_value_control: three instances (default, coupled floor,
// wrapping) on a 1024 Hz clock model; expectations are queued and checked per transaction.
module tb_ramp_value_control;

   logic FF_CLOCK;
   logic RESET;
   int   total = 0;
   int   bad   = 0;

   typedef struct {
      int    sel;
      int    field;
      int    val;
      string tag;
   } exp_t;

   exp_t sb[$];

   ramp_value_control_if #(.WIDTH(12)) if_a ();
   ramp_value_control_if #(.WIDTH(12)) if_b ();
   ramp_value_control_if #(.WIDTH(12)) if_c ();

   ramp_value_control #(.WIDTH(12), .RESET_VAL(4095), .CLK_HZ(1024), .BASE_HZ(2),
                        .COUPLE(0), .WRAP(0))
      dut_a (.FF_CLOCK(FF_CLOCK), .RESET(RESET), .bus(if_a));
   ramp_value_control #(.WIDTH(12), .RESET_VAL(100), .CLK_HZ(1024), .BASE_HZ(2),
                        .COUPLE(1), .WRAP(0))
      dut_b (.FF_CLOCK(FF_CLOCK), .RESET(RESET), .bus(if_b));
   ramp_value_control #(.WIDTH(12), .RESET_VAL(4095), .CLK_HZ(1024), .BASE_HZ(2),
                        .COUPLE(0), .WRAP(1))
      dut_c (.FF_CLOCK(FF_CLOCK), .RESET(RESET), .bus(if_c));

   initial FF_CLOCK = 1'b0;
   always #5 FF_CLOCK = ~FF_CLOCK;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", tag, act, exp);
      end else begin
         $display("ok   %s: %0d", tag, act);
      end
   endtask

   function automatic int obs(input int sel, input int field);
      int r;
      r = 0;
      case (sel)
         0: r = (field == 0) ? int'(if_a.VALUE) : (field == 1) ? int'(if_a.STAGE) : int'(if_a.AT_LIMIT);
         1: r = (field == 0) ? int'(if_b.VALUE) : (field == 1) ? int'(if_b.STAGE) : int'(if_b.AT_LIMIT);
         default: r = (field == 0) ? int'(if_c.VALUE) : (field == 1) ? int'(if_c.STAGE) : int'(if_c.AT_LIMIT);
      endcase
      return r;
   endfunction

   task automatic push(input int sel, input int field, input int val, input string tag);
      exp_t e;
      e.sel = sel; e.field = field; e.val = val; e.tag = tag;
      sb.push_back(e);
   endtask

   task automatic drain();
      exp_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         check_val(e.tag, obs(e.sel, e.field), e.val);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge FF_CLOCK);
   endtask

   initial begin
      RESET = 1'b1;
      if_a.ENABLE = 0; if_a.UP = 0; if_a.DOWN = 0; if_a.LOAD = 0; if_a.BOUND = '0; if_a.LOAD_VAL = '0;
      if_b.ENABLE = 0; if_b.UP = 0; if_b.DOWN = 0; if_b.LOAD = 0; if_b.BOUND = '0; if_b.LOAD_VAL = '0;
      if_c.ENABLE = 0; if_c.UP = 0; if_c.DOWN = 0; if_c.LOAD = 0; if_c.BOUND = '0; if_c.LOAD_VAL = '0;
      cyc(2);
      push(0, 0, 4095, "rst_a_value"); push(0, 1, 0, "rst_a_stage"); push(0, 2, 0, "rst_a_atlim");
      push(1, 0, 100, "rst_b_value"); push(2, 0, 4095, "rst_c_value");
      drain();
      RESET = 1'b0;
      cyc(2);

      // Reset in the middle of a hold, then a hold that continues across reset.
      if_a.LOAD = 1; if_a.LOAD_VAL = 12'd4000; cyc(1); if_a.LOAD = 0;
      push(0, 0, 4000, "load_4000"); drain();
      if_a.ENABLE = 1; if_a.UP = 1; cyc(3);
      push(0, 0, 4001, "first_step_up"); drain();
      #2 RESET = 1'b1;
      #1 push(0, 0, 4095, "async_reset_value"); drain();
      @(negedge FF_CLOCK);
      RESET = 1'b0; if_a.UP = 0; if_a.DOWN = 1;
      cyc(600);
      push(0, 0, 4095, "no_step_after_reset"); drain();
      if_a.DOWN = 0; cyc(1); if_a.DOWN = 1; cyc(1);
      push(0, 0, 4094, "step_after_gap"); drain();
      if_a.ENABLE = 0; if_a.DOWN = 0; cyc(2);

      // Stage-0 cadence: steps on posedges 1, 513, 1025 of the hold.
      if_b.ENABLE = 1; if_b.DOWN = 1;
      cyc(1);    push(1, 0, 99, "down_first");    drain();
      cyc(1023); push(1, 0, 98, "down_1024clk");  drain();
      cyc(1);    push(1, 0, 97, "down_1025clk");  push(1, 1, 0, "down_stage0"); drain();
      if_b.ENABLE = 0; if_b.DOWN = 0; cyc(2);

      // Coupled floor: approach, hold at floor, then floor moves above value.
      if_b.BOUND = 12'd50; if_b.LOAD = 1; if_b.LOAD_VAL = 12'd52; cyc(1); if_b.LOAD = 0;
      push(1, 0, 52, "couple_load52"); drain();
      if_b.ENABLE = 1; if_b.DOWN = 1;
      cyc(1);   push(1, 0, 51, "couple_51"); drain();
      cyc(512); push(1, 0, 50, "couple_50"); drain();
      cyc(587); push(1, 0, 50, "couple_hold50"); push(1, 2, 1, "couple_atlimit"); drain();
      if_b.BOUND = 12'd60;
      cyc(436); push(1, 0, 50, "bound_wait"); drain();
      cyc(1);   push(1, 0, 60, "bound_jump60"); drain();
      if_b.ENABLE = 0; if_b.DOWN = 0; cyc(1);
      push(1, 2, 0, "atlimit_release"); drain();
      if_b.LOAD = 1; if_b.LOAD_VAL = 12'd10; cyc(1); if_b.LOAD = 0;
      push(1, 0, 60, "load_clamp_floor"); drain();

      // Nine-second hold from 0: value counts 4 / 8 / 64 / 384 / 512 per stage span.
      if_a.LOAD = 1; if_a.LOAD_VAL = '0; cyc(1); if_a.LOAD = 0;
      push(0, 0, 0, "load_0"); drain();
      if_a.ENABLE = 1; if_a.UP = 1;
      cyc(2047); push(0, 1, 0, "stage0_at_2047"); push(0, 0, 4, "value_2047"); drain();
      cyc(1);    push(0, 1, 1, "stage1_at_2s"); push(0, 0, 4, "value_2s"); drain();
      cyc(1);    push(0, 0, 5, "stage1_first"); drain();
      cyc(1023); push(0, 1, 2, "stage2_at_3s"); push(0, 0, 12, "value_3s"); drain();
      cyc(2048); push(0, 1, 3, "stage3_at_5s"); push(0, 0, 76, "value_5s"); drain();
      cyc(3072); push(0, 1, 4, "stage4_at_8s"); push(0, 0, 460, "value_8s"); drain();
      cyc(1024); push(0, 0, 972, "value_9s"); push(0, 1, 4, "stage_9s"); drain();
      if_a.UP = 0; cyc(1);
      push(0, 0, 972, "release_value"); push(0, 1, 0, "release_stage"); drain();

      // Both directions pressed: nothing moves.
      if_a.UP = 1; if_a.DOWN = 1; cyc(10);
      push(0, 0, 972, "updown_value"); push(0, 1, 0, "updown_stage"); push(0, 2, 0, "updown_atlim"); drain();
      if_a.UP = 0; if_a.DOWN = 0; cyc(1);

      // Load wins over a step in the same cycle.
      if_a.DOWN = 1; if_a.LOAD = 1; if_a.LOAD_VAL = 12'd4095; cyc(1); if_a.LOAD = 0;
      push(0, 0, 4095, "load_over_step"); drain();
      cyc(5); push(0, 0, 4095, "no_late_step"); drain();
      if_a.DOWN = 0; cyc(1);
      if_a.UP = 1; cyc(2);
      push(0, 0, 4095, "sat_at_hi"); push(0, 2, 1, "sat_atlimit"); drain();
      if_a.UP = 0; if_a.ENABLE = 0; cyc(1);

      // Wrap instance: one-cycle presses cross the ends.
      if_c.ENABLE = 1; if_c.UP = 1; cyc(1); if_c.UP = 0; if_c.ENABLE = 0;
      push(2, 0, 0, "wrap_up"); push(2, 2, 0, "wrap_atlim_up"); drain();
      cyc(1);
      if_c.ENABLE = 1; if_c.DOWN = 1; cyc(1); if_c.DOWN = 0; if_c.ENABLE = 0;
      push(2, 0, 4095, "wrap_down"); push(2, 2, 0, "wrap_atlim_dn"); drain();
      cyc(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
